// File: rtl/sseg_pkg.sv
// Shared types and helpers for the seven-segment scan driver.
// Optional feature macro: LEADING_ZERO_BLANK_EN.
package sseg_pkg;

  typedef logic [3:0] nibble_t;

  localparam int MAX_DIGITS = 8;

  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sseg_digit_scanner_if.sv
// Scan driver bus: load side inputs and display side outputs.
// Optional feature macro: LEADING_ZERO_BLANK_EN.
interface sseg_digit_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  import sseg_pkg::*;

  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  nibble_t                 num;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    dp;
  logic                    frame_start;

  modport master (
    output en, load, value, dp_in,
    input  num, anode, dp, frame_start
  );

  modport slave (
    input  en, load, value, dp_in,
    output num, anode, dp, frame_start
  );

endinterface

// File: rtl/sseg_digit_scanner_prescaler.sv
// Refresh slot timer: counts while enabled and ticks at slot end.
// Optional feature macro: LEADING_ZERO_BLANK_EN (not used here).
module sseg_refresh_prescaler #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sseg_digit_scanner.sv
// N-digit multiplexed 7-seg scan driver with frame-safe double buffer.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module sseg_digit_scanner
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input logic                 clk,
  input logic                 rst_n,
  sseg_digit_scanner_if.slave bus
);
  localparam int IW = idx_w(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] OFF =
    ANODE_OFF[NUM_DIGITS-1:0];

  logic                  tick;
  logic                  wrap;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         active;
  logic [VW-1:0]         pending;
  logic [NUM_DIGITS-1:0] dp_act;
  logic [NUM_DIGITS-1:0] dp_pend;
  logic                  pend_valid;
  logic                  fs_pend;
  logic                  blank;
  nibble_t               cur_nib;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] sel;

  sseg_refresh_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (bus.en),
    .tick (tick)
  );

  assign wrap = tick && (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  // A load on the wrap tick bypasses pending so no stale frame is shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= '0;
      dp_act     <= '0;
      pending    <= '0;
      dp_pend    <= '0;
      pend_valid <= 1'b0;
    end else if (wrap) begin
      pend_valid <= 1'b0;
      if (bus.load) begin
        active <= bus.value;
        dp_act <= bus.dp_in;
      end else if (pend_valid) begin
        active <= pending;
        dp_act <= dp_pend;
      end
    end else if (bus.load) begin
      pending    <= bus.value;
      dp_pend    <= bus.dp_in;
      pend_valid <= 1'b1;
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    sel     = OFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib = active[4*k +: 4];
        cur_dp  = dp_act[k];
        sel[k]  = 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;

  always_comb begin
    msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (active[4*k +: 4] != 4'h0) msd = IW'(k);
    end
  end

  assign blank = (idx > msd);
`else
  assign blank = 1'b0;
`endif

  // frame_start waits for the first enabled output update after a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_pend <= 1'b0;
    end else if (wrap) begin
      fs_pend <= 1'b1;
    end else if (bus.en) begin
      fs_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.anode       <= OFF;
      bus.num         <= '0;
      bus.dp          <= 1'b0;
      bus.frame_start <= 1'b0;
    end else if (bus.en) begin
      bus.anode       <= blank ? OFF : sel;
      bus.num         <= cur_nib;
      bus.dp          <= cur_dp & ~blank;
      bus.frame_start <= fs_pend;
    end else begin
      bus.anode       <= OFF;
      bus.frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sseg_digit_scanner.sv
// Randomized bench for sseg_digit_scanner against a slot/frame model.
// Optional feature macro: LEADING_ZERO_BLANK_EN changes expected blanking.
module tb_sseg_digit_scanner;
  localparam int N   = 4;
  localparam int DIV = 4;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  sseg_digit_scanner_if #(.NUM_DIGITS(N)) bus ();

  sseg_digit_scanner #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: slot countdown, digit index, frame buffers
  int          m_idx;
  int          m_left;
  logic [15:0] m_act;
  logic [15:0] m_pend;
  logic [3:0]  m_dpa;
  logic [3:0]  m_dpp;
  bit          m_pv;
  bit          m_fsp;
  logic [3:0]  x_anode;
  logic [3:0]  x_num;
  logic        x_dp;
  logic        x_fs;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit blanked(input int k, input logic [15:0] a);
`ifdef LEADING_ZERO_BLANK_EN
    return (k > 0) && ((a >> (4 * k)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    m_idx = 0; m_left = DIV;
    m_act = '0; m_pend = '0;
    m_dpa = '0; m_dpp = '0;
    m_pv = 0; m_fsp = 0;
    x_anode = 4'hF; x_num = 4'h0;
    x_dp = 1'b0; x_fs = 1'b0;
  endtask

  task automatic m_step(input bit e, input bit l,
                        input logic [15:0] v,
                        input logic [3:0] d);
    bit w;
    bit b;
    if (e) begin
      b = blanked(m_idx, m_act);
      x_anode = b ? 4'hF : ~(4'b0001 << m_idx);
      x_num   = 4'((m_act >> (4 * m_idx)) & 16'hF);
      x_dp    = m_dpa[m_idx] & ~b;
      x_fs    = m_fsp;
      m_fsp   = 0;
    end else begin
      x_anode = 4'hF;
      x_fs    = 1'b0;
    end
    w = e && (m_left == 1) && (m_idx == N - 1);
    if (e) begin
      m_left--;
      if (m_left == 0) begin
        m_left = DIV;
        m_idx  = (m_idx + 1) % N;
      end
    end
    if (w) begin
      m_fsp = 1;
      if (l) begin
        m_act = v; m_dpa = d;
      end else if (m_pv) begin
        m_act = m_pend; m_dpa = m_dpp;
      end
      m_pv = 0;
    end else if (l) begin
      m_pend = v; m_dpp = d; m_pv = 1;
    end
  endtask

  task automatic cyc(input bit e, input bit l,
                     input logic [15:0] v,
                     input logic [3:0] d);
    bus.en = e; bus.load = l;
    bus.value = v; bus.dp_in = d;
    m_step(e, l, v, d);
    @(posedge clk); #1;
    check("anode", 16'(bus.anode), 16'(x_anode));
    check("num", 16'(bus.num), 16'(x_num));
    check("dp", 16'(bus.dp), 16'(x_dp));
    check("frame_start", 16'(bus.frame_start), 16'(x_fs));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1, 0, 16'h0, 4'h0);
  endtask

  task automatic rand_cycles(input int n);
    bit          e;
    bit          l;
    logic [15:0] v;
    logic [3:0]  d;
    repeat (n) begin
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 7) == 0);
      v = 16'($urandom);
      if ($urandom_range(0, 2) == 0) v = v & 16'h00FF;
      d = 4'($urandom);
      cyc(e, l, v, d);
    end
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    check("rst_anode", 16'(bus.anode), 16'hF);
    check("rst_num", 16'(bus.num), 16'h0);
    check("rst_dp", 16'(bus.dp), 16'h0);
    check("rst_fs", 16'(bus.frame_start), 16'h0);
    m_reset();
    bus.en = 1'b0; bus.load = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load_on_wrap(input logic [15:0] v);
    int budget;
    budget = 64;
    while (!(m_left == 1 && m_idx == N - 1) && budget > 0) begin
      cyc(1, 0, 16'h0, 4'h0);
      budget--;
    end
    check("wrap_reached", 16'(budget > 0), 16'h1);
    cyc(1, 1, v, 4'h5);
  endtask

  initial begin
    errs = 0; checks = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.load = 1'b0;
    bus.value = '0; bus.dp_in = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(6);
    do_reset();
    cyc(1, 1, 16'h1234, 4'h2);
    idle(40);
    repeat (6) cyc(1, 0, 16'h0, 4'h0);
    cyc(1, 1, 16'hABCD, 4'h8);
    idle(40);
    load_on_wrap(16'h9876);
    idle(20);
    repeat (10) cyc(0, 0, 16'h0, 4'h0);
    idle(20);
    cyc(1, 1, 16'h0050, 4'hF);
    idle(40);
    load_on_wrap(16'h0007);
    idle(20);
    rand_cycles(500);
    do_reset();
    rand_cycles(300);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
